// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: BEQ/BNE/J/JAL decode with a saturating-counter BHT, target prediction and mispredict tracking
module branch_predictor_bht #(
  parameter int IDX_W = 4,
  parameter int CTR_W = 2,
  parameter int INIT_CTR = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  output logic             pred_valid,
  output logic             pred_is_branch,
  output logic             pred_is_jump,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] miss_count
);
  localparam int N = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CMAX = '1;
  logic [CTR_W-1:0] bht [N];
  logic [5:0] op;
  logic is_br, is_j, tk, miss;
  logic [CTR_W-1:0] ctr, uctr;
  logic [31:0] pc4, simm, tgt;
  // decode the IF opcode and form direction and target from the pre-update counter
  always_comb begin
    op = if_instr[31:26];
    is_br = op == 6'b000100 || op == 6'b000101;
    is_j = op == 6'b000010 || op == 6'b000011;
    ctr = bht[if_pc[IDX_W+1:2]];
    uctr = bht[upd_pc[IDX_W+1:2]];
    tk = is_br ? ctr[CTR_W-1] : is_j;
    pc4 = if_pc + 32'd4;
    simm = {{14{if_instr[15]}}, if_instr[15:0], 2'b00};
    tgt = is_j ? {pc4[31:28], if_instr[25:0], 2'b00} : tk ? pc4 + simm : pc4;
    miss = upd_valid && upd_taken != upd_pred_taken;
  end
  // register predictions, train the addressed counter and track mispredictions
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bht[i] <= CTR_W'(INIT_CTR);
      pred_valid <= 1'b0;
      pred_is_branch <= 1'b0;
      pred_is_jump <= 1'b0;
      pred_taken <= 1'b0;
      pred_target <= 32'd0;
      mispredict <= 1'b0;
      miss_count <= '0;
    end else begin
      pred_valid <= if_valid;
      pred_is_branch <= if_valid && is_br;
      pred_is_jump <= if_valid && is_j;
      pred_taken <= if_valid && tk;
      pred_target <= if_valid ? tgt : 32'd0;
      if (upd_valid)
        bht[upd_pc[IDX_W+1:2]] <= upd_taken ? (uctr == CMAX ? uctr : uctr + CTR_W'(1))
                                            : (uctr == '0 ? uctr : uctr - CTR_W'(1));
      mispredict <= miss;
      if (miss && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
    end
  end
endmodule
